// File: rtl/trap_csr_pkg.sv
// Shared trap/CSR encodings for the machine-mode trap path, plus the Zicsr
// read-modify-write merge helper.
package trap_csr_pkg;

    localparam logic [4:0] TRAP_NONE         = 5'b11111;
    localparam logic [4:0] TRAP_ILLEGAL_INSN = 5'h02;
    localparam logic [4:0] TRAP_BREAKPOINT   = 5'h03;
    localparam logic [4:0] TRAP_ECALL_M      = 5'h0B;
    localparam logic [4:0] TRAP_EXT_IRQ      = 5'h1B;

    localparam logic [11:0] CSR_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE       = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_ADDR_MIP       = 12'h344;
    localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_merge(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_RW: res = wdata;
            CSR_OP_RS: res = old_val | wdata;
            CSR_OP_RC: res = old_val & ~wdata;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trap_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment in that cycle.
module trap_csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // next count: half replacement or increment
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) begin
                cnt_d[31:0] = wdata_i;
            end else begin
                cnt_d[31:0] = cnt_q[31:0];
            end
            if (wr_hi_i) begin
                cnt_d[63:32] = wdata_i;
            end else begin
                cnt_d[63:32] = cnt_q[63:32];
            end
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSRs: trap entry/return state, Zicsr access, mcycle/minstret
// and the synchronised, gated external interrupt request.
module trap_csr
    import trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter int          SYNC_STAGES  = 2,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_taken,
    input  logic        trap_return,
    input  logic [4:0]  trap_src,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        instret,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_rdata,
    output logic [31:0] mepc_rdata,
    input  logic        ext_irq_raw,
    output logic        external_int
);

    logic                   mstatus_mie_q,  mstatus_mie_d;
    logic                   mstatus_mpie_q, mstatus_mpie_d;
    logic                   mie_meie_q,     mie_meie_d;
    logic [31:0]            mtvec_q,        mtvec_d;
    logic [31:0]            mscratch_q,     mscratch_d;
    logic [31:0]            mepc_q,         mepc_d;
    logic [31:0]            mcause_q,       mcause_d;
    logic [31:0]            mtval_q,        mtval_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic        sync_irq_s;
    logic        entry_s;
    logic        return_s;
    logic        addr_hit_s;
    logic [31:0] rdata_s;
    logic        wr_s;
    logic [31:0] new_val_s;
    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;

    assign sync_irq_s = sync_q[SYNC_STAGES-1];
    assign entry_s    = trap_taken && (trap_src != TRAP_NONE);
    assign return_s   = trap_taken && trap_return && (trap_src == TRAP_NONE);

    // read mux and address decode (pre-update values)
    always_comb begin
        rdata_s    = 32'd0;
        addr_hit_s = 1'b1;
        case (csr_addr)
            CSR_ADDR_MSTATUS:   rdata_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            CSR_ADDR_MIE:       rdata_s = {20'd0, mie_meie_q, 11'd0};
            CSR_ADDR_MTVEC:     rdata_s = mtvec_q;
            CSR_ADDR_MSCRATCH:  rdata_s = mscratch_q;
            CSR_ADDR_MEPC:      rdata_s = mepc_q;
            CSR_ADDR_MCAUSE:    rdata_s = mcause_q;
            CSR_ADDR_MTVAL:     rdata_s = mtval_q;
            CSR_ADDR_MIP:       rdata_s = {20'd0, sync_irq_s, 11'd0};
            CSR_ADDR_MCYCLE:    rdata_s = mcycle_s[31:0];
            CSR_ADDR_MCYCLEH:   rdata_s = mcycle_s[63:32];
            CSR_ADDR_MINSTRET:  rdata_s = minstret_s[31:0];
            CSR_ADDR_MINSTRETH: rdata_s = minstret_s[63:32];
            default: begin
                rdata_s    = 32'd0;
                addr_hit_s = 1'b0;
            end
        endcase
    end

    assign csr_rdata   = rdata_s;
    assign csr_illegal = csr_en && !addr_hit_s;

    // Set/clear with a zero mask is a pure read; a trap in the same cycle drops the write.
    assign wr_s = csr_en && (csr_op != CSR_OP_READ) && addr_hit_s && !entry_s && !return_s
                  && !(((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && (csr_wdata == 32'd0));
    assign new_val_s = csr_merge(csr_op, rdata_s, csr_wdata);

    // next-state for trap state and software-writable CSRs
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (entry_s) begin
            mepc_d         = trap_pc & 32'hFFFF_FFFC;
            mcause_d       = {trap_src[4], 27'd0, trap_src[3:0]};
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (return_s) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_s) begin
            case (csr_addr)
                CSR_ADDR_MSTATUS: begin
                    mstatus_mie_d  = new_val_s[3];
                    mstatus_mpie_d = new_val_s[7];
                end
                CSR_ADDR_MIE:      mie_meie_d = new_val_s[11];
                CSR_ADDR_MTVEC:    mtvec_d    = new_val_s & 32'hFFFF_FFFC;
                CSR_ADDR_MSCRATCH: mscratch_d = new_val_s;
                CSR_ADDR_MEPC:     mepc_d     = new_val_s & 32'hFFFF_FFFC;
                CSR_ADDR_MCAUSE:   mcause_d   = new_val_s;
                CSR_ADDR_MTVAL:    mtval_d    = new_val_s;
                default:           mtvec_d    = mtvec_q;
            endcase
        end else begin
            mstatus_mie_d = mstatus_mie_q;
        end
    end

    // CSR state and interrupt synchroniser registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & 32'hFFFF_FFFC;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
            sync_q         <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            sync_q         <= {sync_q[SYNC_STAGES-2:0], ext_irq_raw};
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            trap_csr_counter64 u_mcycle (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc_i   (1'b1),
                .wr_lo_i (wr_s && (csr_addr == CSR_ADDR_MCYCLE)),
                .wr_hi_i (wr_s && (csr_addr == CSR_ADDR_MCYCLEH)),
                .wdata_i (new_val_s),
                .value_o (mcycle_s)
            );
            trap_csr_counter64 u_minstret (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc_i   (instret),
                .wr_lo_i (wr_s && (csr_addr == CSR_ADDR_MINSTRET)),
                .wr_hi_i (wr_s && (csr_addr == CSR_ADDR_MINSTRETH)),
                .wdata_i (new_val_s),
                .value_o (minstret_s)
            );
        end else begin : g_no_counters
            assign mcycle_s   = 64'd0;
            assign minstret_s = 64'd0;
        end
    endgenerate

    assign mtvec_rdata  = mtvec_q;
    assign mepc_rdata   = mepc_q;
    assign external_int = sync_irq_s && mstatus_mie_q && mie_meie_q;

endmodule

// File: tb/tb_trap_csr.sv
// Self-checking bench for trap_csr: a vector table of single-cycle CSR/trap events
// with read-back expectations, plus sequences for interrupts, counters and reset.
module tb_trap_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_taken, trap_return, instret, csr_en, ext_irq_raw;
    logic [4:0]  trap_src;
    logic [31:0] trap_pc, trap_tval, csr_wdata;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, mtvec_rdata, mepc_rdata;
    logic        csr_illegal, external_int;

    always #5 clk = ~clk;

    trap_csr dut (
        .clk(clk), .rst_n(rst_n),
        .trap_taken(trap_taken), .trap_return(trap_return), .trap_src(trap_src),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .instret(instret),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .ext_irq_raw(ext_irq_raw), .external_int(external_int)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        tt;
        logic        tr;
        logic [4:0]  src;
        logic [31:0] pc;
        logic [31:0] tval;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic [11:0] chk_addr;
        logic [31:0] chk_val;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    task automatic sb_push(input string n, input logic [31:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        string       n;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
        end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", n, act, e);
            end
        end
    endtask

    task automatic out_chk(input string n, input logic [31:0] act, input logic [31:0] e);
        sb_push(n, e);
        sb_pop(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_taken = 1'b0; trap_return = 1'b0; trap_src = 5'h1F;
        trap_pc = 32'd0; trap_tval = 32'd0; instret = 1'b0;
        csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'd0; csr_wdata = 32'd0;
    endtask

    task automatic rd_chk(input logic [11:0] a, input string n, input logic [31:0] e);
        csr_en = 1'b1; csr_op = 2'b00; csr_addr = a;
        sb_push(n, e);
        #1;
        sb_pop(csr_rdata);
        csr_en = 1'b0;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        tick();
        idle();
    endtask

    initial begin
        //          en  op     addr     wdata          tt tr src    pc            tval          exp_rd        ill  chk_addr chk_val
        tbl[0]  = '{1, 2'b01, 12'h305, 32'h8000_0103, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0000, 0, 12'h305, 32'h8000_0100};
        tbl[1]  = '{1, 2'b01, 12'h300, 32'h0000_0008, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_1800, 0, 12'h300, 32'h0000_1808};
        tbl[2]  = '{0, 2'b00, 12'h000, 32'h0,         1, 0, 5'h02, 32'h1006,     32'h1006,     32'h0,         0, 12'h341, 32'h0000_1004};
        tbl[3]  = '{0, 2'b00, 12'h000, 32'h0,         0, 0, 5'h1F, 32'h0,        32'h0,        32'h0,         0, 12'h342, 32'h0000_0002};
        tbl[4]  = '{0, 2'b00, 12'h000, 32'h0,         0, 0, 5'h1F, 32'h0,        32'h0,        32'h0,         0, 12'h343, 32'h0000_1006};
        tbl[5]  = '{0, 2'b00, 12'h000, 32'h0,         0, 0, 5'h1F, 32'h0,        32'h0,        32'h0,         0, 12'h300, 32'h0000_1880};
        tbl[6]  = '{0, 2'b00, 12'h000, 32'h0,         1, 1, 5'h1F, 32'h0,        32'h0,        32'h0,         0, 12'h300, 32'h0000_1888};
        tbl[7]  = '{0, 2'b00, 12'h000, 32'h0,         1, 1, 5'h05, 32'h2000,     32'h0,        32'h0,         0, 12'h300, 32'h0000_1880};
        tbl[8]  = '{0, 2'b00, 12'h000, 32'h0,         0, 0, 5'h1F, 32'h0,        32'h0,        32'h0,         0, 12'h342, 32'h0000_0005};
        tbl[9]  = '{1, 2'b10, 12'h300, 32'h0000_0008, 1, 0, 5'h03, 32'h3000,     32'h0,        32'h0000_1880, 0, 12'h300, 32'h0000_1800};
        tbl[10] = '{1, 2'b01, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0000, 1, 12'h340, 32'h0000_0000};
        tbl[11] = '{1, 2'b01, 12'h340, 32'hA5A5_5A5A, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0000, 0, 12'h340, 32'hA5A5_5A5A};
        tbl[12] = '{1, 2'b10, 12'h340, 32'h0000_0F00, 0, 0, 5'h1F, 32'h0,        32'h0,        32'hA5A5_5A5A, 0, 12'h340, 32'hA5A5_5F5A};
        tbl[13] = '{1, 2'b11, 12'h340, 32'hA000_000A, 0, 0, 5'h1F, 32'h0,        32'h0,        32'hA5A5_5F5A, 0, 12'h340, 32'h05A5_5F50};
        tbl[14] = '{1, 2'b10, 12'h340, 32'h0000_0000, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h05A5_5F50, 0, 12'h340, 32'h05A5_5F50};
        tbl[15] = '{1, 2'b01, 12'h344, 32'hFFFF_FFFF, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0000, 0, 12'h344, 32'h0000_0000};
        tbl[16] = '{1, 2'b01, 12'h341, 32'h0000_1237, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_3000, 0, 12'h341, 32'h0000_1234};
        tbl[17] = '{1, 2'b01, 12'h304, 32'hFFFF_FFFF, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0000, 0, 12'h304, 32'h0000_0800};
        tbl[18] = '{1, 2'b01, 12'h342, 32'h8000_000B, 0, 0, 5'h1F, 32'h0,        32'h0,        32'h0000_0003, 0, 12'h342, 32'h8000_000B};

        idle();
        ext_irq_raw = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // reset state
        out_chk("rst_external_int", {31'd0, external_int}, 32'd0);
        out_chk("rst_mtvec_rdata", mtvec_rdata, 32'd0);
        out_chk("rst_mepc_rdata", mepc_rdata, 32'd0);
        rd_chk(12'h300, "rst_mstatus", 32'h0000_1800);
        rd_chk(12'h304, "rst_mie", 32'd0);
        rd_chk(12'h305, "rst_mtvec", 32'd0);
        rd_chk(12'h340, "rst_mscratch", 32'd0);
        rd_chk(12'h341, "rst_mepc", 32'd0);
        rd_chk(12'h342, "rst_mcause", 32'd0);
        rd_chk(12'h343, "rst_mtval", 32'd0);
        rd_chk(12'h344, "rst_mip", 32'd0);
        rd_chk(12'hB02, "rst_minstret", 32'd0);
        rd_chk(12'hB82, "rst_minstreth", 32'd0);
        rd_chk(12'hB80, "rst_mcycleh", 32'd0);
        tick();

        // table of single-cycle events with read-back
        for (int i = 0; i < NV; i++) begin
            idle();
            csr_en = tbl[i].en; csr_op = tbl[i].op; csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
            trap_taken = tbl[i].tt; trap_return = tbl[i].tr; trap_src = tbl[i].src;
            trap_pc = tbl[i].pc; trap_tval = tbl[i].tval;
            #1;
            if (tbl[i].en) begin
                out_chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
                out_chk($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, tbl[i].exp_ill});
            end
            sb_push($sformatf("vec%0d_readback", i), tbl[i].chk_val);
            tick();
            idle();
            csr_en = 1'b1; csr_addr = tbl[i].chk_addr;
            #1;
            sb_pop(csr_rdata);
            csr_en = 1'b0;
            tick();
        end
        out_chk("mtvec_rdata", mtvec_rdata, 32'h8000_0100);
        out_chk("mepc_rdata", mepc_rdata, 32'h0000_1234);

        // interrupt synchroniser, gating and entry
        csr_wr(2'b01, 12'h300, 32'h0000_0008);
        rd_chk(12'h300, "irq_mstatus_mie", 32'h0000_1808);
        ext_irq_raw = 1'b1;
        tick();
        out_chk("irq_after_1_edge", {31'd0, external_int}, 32'd0);
        tick();
        out_chk("irq_after_2_edges", {31'd0, external_int}, 32'd1);
        rd_chk(12'h344, "irq_mip", 32'h0000_0800);
        trap_taken = 1'b1; trap_src = 5'h1B; trap_pc = 32'h0000_4000;
        tick();
        idle();
        out_chk("irq_drop_after_entry", {31'd0, external_int}, 32'd0);
        out_chk("irq_mepc_rdata", mepc_rdata, 32'h0000_4000);
        rd_chk(12'h342, "irq_mcause", 32'h8000_000B);
        rd_chk(12'h300, "irq_mstatus", 32'h0000_1880);
        ext_irq_raw = 1'b0;

        // mcycle wrap
        csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        rd_chk(12'hB00, "mcycle_lo_full", 32'hFFFF_FFFF);
        rd_chk(12'hB80, "mcycle_hi_full", 32'hFFFF_FFFF);
        tick();
        rd_chk(12'hB80, "mcycle_hi_wrap", 32'd0);
        rd_chk(12'hB00, "mcycle_lo_wrap", 32'd0);

        // minstret increment and write-over-increment
        instret = 1'b1;
        repeat (3) tick();
        instret = 1'b0;
        rd_chk(12'hB02, "minstret_plus3", 32'd3);
        instret = 1'b1;
        csr_wr(2'b01, 12'hB02, 32'h0000_0100);
        rd_chk(12'hB02, "minstret_written", 32'h0000_0100);
        rd_chk(12'hB82, "minstreth_zero", 32'd0);

        // reset wins over simultaneous trap and CSR write
        rst_n = 1'b0;
        trap_taken = 1'b1; trap_src = 5'h02; trap_pc = 32'h0000_5000;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1;
        tick();
        rst_n = 1'b1;
        idle();
        rd_chk(12'h341, "rstwin_mepc", 32'd0);
        rd_chk(12'h340, "rstwin_mscratch", 32'd0);
        rd_chk(12'h300, "rstwin_mstatus", 32'h0000_1800);
        rd_chk(12'h305, "rstwin_mtvec", 32'd0);
        out_chk("rstwin_external_int", {31'd0, external_int}, 32'd0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
